// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT control, branch/jump target selection and return-address stack.
// Define PC_SEQ_RAS_EN to build the return-address stack; otherwise call acts as jmp and ret is ignored.
module pc_sequencer #(
    parameter logic [15:0] RESET_VEC = 16'h0000,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_cur,
    input  logic        stall,
    input  logic        halt,
    input  logic        resume,
    input  logic        br_taken,
    input  logic [7:0]  br_off,
    input  logic        jmp,
    input  logic [15:0] jmp_addr,
    input  logic        call,
    input  logic        ret,
    output logic [15:0] next_pc,
    output logic        pc_we,
    output logic        halted,
    output logic        ras_ovf,
    output logic        ras_unf
);
    localparam int unsigned AW = 16;

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t        state;
    logic          act;
    logic          do_ret;
    logic          do_call;
    logic          ras_empty;
    logic [AW-1:0] ras_top;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] br_tgt;

    // A request only acts in a RUN cycle that is neither stalled nor halting.
    assign act    = (state == RUN) && !stall && !halt;
    assign pc_inc = pc_cur + AW'(1);
    assign br_tgt = pc_inc + {{8{br_off[7]}}, br_off};
    assign halted = (state == HALT);

`ifdef PC_SEQ_RAS_EN
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam int unsigned IW = $clog2(RAS_DEPTH);

    logic [AW-1:0] ras [RAS_DEPTH];
    logic [CW-1:0] ras_cnt;
    logic          ras_full;

    assign do_ret    = act && ret;
    assign do_call   = act && !ret && call;
    assign ras_empty = (ras_cnt == CW'(0));
    assign ras_full  = (ras_cnt == CW'(RAS_DEPTH));
    assign ras_top   = ras[IW'(ras_cnt - CW'(1))];

    // Stack pointer and sticky error flags; a rejected push/pop leaves the stack as it was.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_cnt <= CW'(0);
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else if (do_ret) begin
            if (ras_empty) ras_unf <= 1'b1;
            else           ras_cnt <= ras_cnt - CW'(1);
        end else if (do_call) begin
            if (ras_full)  ras_ovf <= 1'b1;
            else           ras_cnt <= ras_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_call && !ras_full) ras[IW'(ras_cnt)] <= pc_inc;
    end
`else
    logic unused_ret;

    assign unused_ret = ret;
    assign do_ret     = 1'b0;
    assign do_call    = act && call;
    assign ras_empty  = 1'b1;
    assign ras_top    = '0;
    assign ras_ovf    = 1'b0;
    assign ras_unf    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (halt && !stall) state <= HALT;
                HALT:    if (resume) state <= RUN;
                default: state <= BOOT;
            endcase
        end
    end

    // Zero-latency target selection: ret > call > jmp > br_taken > sequential.
    always_comb begin
        next_pc = pc_cur;
        pc_we   = 1'b0;
        if (rst) begin
            next_pc = RESET_VEC;
        end else if (state == BOOT) begin
            next_pc = RESET_VEC;
            pc_we   = 1'b1;
        end else if (act) begin
            pc_we = 1'b1;
            if (do_ret && !ras_empty) next_pc = ras_top;
            else if (do_ret)          next_pc = pc_inc;
            else if (do_call || jmp)  next_pc = jmp_addr;
            else if (br_taken)        next_pc = br_tgt;
            else                      next_pc = pc_inc;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table plus call/ret, halt and reset sequences.
module tb_pc_sequencer;
    localparam logic [15:0] RV = 16'h8000;
`ifdef PC_SEQ_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] pc;
        logic        stall, halt, resume, br, jmp, call, ret;
        logic [7:0]  off;
        logic [15:0] addr;
    } stim_t;

    typedef struct packed {
        logic [15:0] npc;
        logic        we, halted, ovf, unf;
    } exp_t;

    typedef struct {
        logic [15:0] pc;
        logic        stall, br, jmp;
        logic [7:0]  off;
        logic [15:0] addr;
        logic [15:0] exp_pc;
        logic        exp_we;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pc_cur = '0;
    logic        stall = 1'b0, halt = 1'b0, resume = 1'b0, br_taken = 1'b0;
    logic [7:0]  br_off = '0;
    logic        jmp = 1'b0, call = 1'b0, ret = 1'b0;
    logic [15:0] jmp_addr = '0;
    logic [15:0] next_pc;
    logic        pc_we, halted, ras_ovf, ras_unf;

    int    checks = 0;
    int    errors = 0;
    logic  e_ovf = 1'b0;
    logic  e_unf = 1'b0;
    exp_t  sb[$];
    string nq[$];
    vec_t  tv[10];

    pc_sequencer #(.RESET_VEC(RV), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .stall(stall), .halt(halt),
        .resume(resume), .br_taken(br_taken), .br_off(br_off), .jmp(jmp),
        .jmp_addr(jmp_addr), .call(call), .ret(ret), .next_pc(next_pc),
        .pc_we(pc_we), .halted(halted), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    function automatic stim_t idle(input logic [15:0] pc);
        stim_t s;
        s    = '0;
        s.pc = pc;
        return s;
    endfunction

    function automatic exp_t ex(input logic [15:0] npc, input logic we, input logic h);
        exp_t e;
        e.npc    = npc;
        e.we     = we;
        e.halted = h;
        e.ovf    = e_ovf;
        e.unf    = e_unf;
        return e;
    endfunction

    task automatic chk(input string nm, input string f, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
        end
    endtask

    task automatic compare();
        exp_t  e;
        string nm;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected entry");
            return;
        end
        e  = sb.pop_front();
        nm = nq.pop_front();
        chk(nm, "next_pc", next_pc, e.npc);
        chk(nm, "pc_we",   16'(pc_we),   16'(e.we));
        chk(nm, "halted",  16'(halted),  16'(e.halted));
        chk(nm, "ras_ovf", 16'(ras_ovf), 16'(e.ovf));
        chk(nm, "ras_unf", 16'(ras_unf), 16'(e.unf));
    endtask

    task automatic drive(input stim_t s);
        pc_cur = s.pc; stall = s.stall; halt = s.halt; resume = s.resume;
        br_taken = s.br; jmp = s.jmp; call = s.call; ret = s.ret;
        br_off = s.off; jmp_addr = s.addr;
    endtask

    task automatic apply(input stim_t s, input exp_t e, input string nm);
        drive(s);
        sb.push_back(e);
        nq.push_back(nm);
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input exp_t e, input string nm);
        sb.push_back(e);
        nq.push_back(nm);
        compare();
    endtask

    initial begin
        stim_t s;
        tv[0] = '{16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h0001, 1'b1};
        tv[1] = '{16'h0010, 1'b0, 1'b1, 1'b0, 8'hFC, 16'h0000, 16'h000D, 1'b1};
        tv[2] = '{16'hFFFF, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1};
        tv[3] = '{16'h0005, 1'b0, 1'b1, 1'b0, 8'h7F, 16'h0000, 16'h0085, 1'b1};
        tv[4] = '{16'h0000, 1'b0, 1'b1, 1'b0, 8'h80, 16'h0000, 16'hFF81, 1'b1};
        tv[5] = '{16'h1234, 1'b0, 1'b0, 1'b1, 8'h00, 16'hABCD, 16'hABCD, 1'b1};
        tv[6] = '{16'h1234, 1'b0, 1'b1, 1'b1, 8'h10, 16'h4321, 16'h4321, 1'b1};
        tv[7] = '{16'h0100, 1'b1, 1'b1, 1'b1, 8'h10, 16'h4321, 16'h0100, 1'b0};
        tv[8] = '{16'hFFFF, 1'b0, 1'b1, 1'b0, 8'h01, 16'h0000, 16'h0001, 1'b1};
        tv[9] = '{16'h0020, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 16'h0021, 1'b1};

        // Reset and boot
        #1 rst = 1'b1;
        #2 check_now(ex(RV, 1'b0, 1'b0), "reset");
        @(posedge clk);
        #1 rst = 1'b0;
        apply(idle(16'h0000), ex(RV, 1'b1, 1'b0), "boot");

        foreach (tv[i]) begin
            s       = idle(tv[i].pc);
            s.stall = tv[i].stall;
            s.br    = tv[i].br;
            s.jmp   = tv[i].jmp;
            s.off   = tv[i].off;
            s.addr  = tv[i].addr;
            apply(s, ex(tv[i].exp_pc, tv[i].exp_we, 1'b0), $sformatf("vec%0d", i));
        end

        // Calls fill the stack; a stalled call in between must not push
        s = idle(16'h0010); s.call = 1'b1; s.addr = 16'h0100;
        apply(s, ex(16'h0100, 1'b1, 1'b0), "call1");
        s.pc = 16'h0020;
        apply(s, ex(16'h0100, 1'b1, 1'b0), "call2");
        s.pc = 16'h0077; s.stall = 1'b1; s.jmp = 1'b1;
        apply(s, ex(16'h0077, 1'b0, 1'b0), "stall_call");
        s.stall = 1'b0; s.jmp = 1'b0;
        s.pc = 16'h0030;
        apply(s, ex(16'h0100, 1'b1, 1'b0), "call3");
        s.pc = 16'h0040;
        apply(s, ex(16'h0100, 1'b1, 1'b0), "call4");
        s.pc = 16'h0050;
        apply(s, ex(16'h0100, 1'b1, 1'b0), "call5_full");
        e_ovf = RAS;
        s.pc = 16'h0060; s.ret = 1'b1;
        apply(s, ex(RAS ? 16'h0041 : 16'h0100, 1'b1, 1'b0), "call_ret");
        s = idle(16'h0200); s.ret = 1'b1;
        apply(s, ex(RAS ? 16'h0031 : 16'h0201, 1'b1, 1'b0), "ret2");
        apply(s, ex(RAS ? 16'h0021 : 16'h0201, 1'b1, 1'b0), "ret3");
        apply(s, ex(RAS ? 16'h0011 : 16'h0201, 1'b1, 1'b0), "ret4");
        apply(s, ex(16'h0201, 1'b1, 1'b0), "ret_empty");
        e_unf = RAS;
        apply(idle(16'h0210), ex(16'h0211, 1'b1, 1'b0), "after_unf");

        // Halt: stalled halt is ignored, then HALT ignores everything until resume
        s = idle(16'h0300); s.halt = 1'b1; s.stall = 1'b1;
        apply(s, ex(16'h0300, 1'b0, 1'b0), "halt_stalled");
        apply(idle(16'h0300), ex(16'h0301, 1'b1, 1'b0), "still_run");
        s = idle(16'h0300); s.halt = 1'b1; s.jmp = 1'b1; s.addr = 16'h0500;
        apply(s, ex(16'h0300, 1'b0, 1'b0), "halt_enter");
        for (int i = 0; i < 10; i++) begin
            s = idle(16'h0300); s.jmp = 1'b1; s.addr = 16'h0500;
            s.call = i[0]; s.ret = i[1]; s.br = i[2]; s.stall = (i == 5);
            apply(s, ex(16'h0300, 1'b0, 1'b1), $sformatf("halt%0d", i));
        end
        s = idle(16'h0300); s.resume = 1'b1; s.jmp = 1'b1; s.addr = 16'h0500;
        apply(s, ex(16'h0300, 1'b0, 1'b1), "resume");
        apply(idle(16'h0300), ex(16'h0301, 1'b1, 1'b0), "resumed_seq");

        // Reset while halted with a partly filled stack and sticky flags set
        s = idle(16'h0010); s.call = 1'b1; s.addr = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            s.pc = 16'(16'h0010 * (i + 1));
            apply(s, ex(16'h0100, 1'b1, 1'b0), $sformatf("refill%0d", i));
        end
        s = idle(16'h0200); s.ret = 1'b1;
        apply(s, ex(RAS ? 16'h0041 : 16'h0201, 1'b1, 1'b0), "pop_a");
        apply(s, ex(RAS ? 16'h0031 : 16'h0201, 1'b1, 1'b0), "pop_b");
        s = idle(16'h0300); s.halt = 1'b1;
        apply(s, ex(16'h0300, 1'b0, 1'b0), "halt2");
        apply(idle(16'h0300), ex(16'h0300, 1'b0, 1'b1), "halted2");
        rst = 1'b1;
        e_ovf = 1'b0;
        e_unf = 1'b0;
        #2 check_now(ex(RV, 1'b0, 1'b0), "rst_async");
        @(posedge clk);
        #1 rst = 1'b0;
        apply(idle(16'h0300), ex(RV, 1'b1, 1'b0), "boot2");
        apply(idle(16'h0000), ex(16'h0001, 1'b1, 1'b0), "run2");
        s = idle(16'h0005); s.ret = 1'b1;
        apply(s, ex(16'h0006, 1'b1, 1'b0), "ret_after_rst");
        e_unf = RAS;
        apply(idle(16'h0006), ex(16'h0007, 1'b1, 1'b0), "unf_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_VEC, 16'h0000, first PC loaded after reset.
REQ-002 Parameter: RAS_DEPTH, 4, return-address-stack entries (2..16).
REQ-003 clk  in  1  clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 pc_cur  in  16  current PC register value.
REQ-006 stall  in  1  hold PC this cycle.
REQ-007 halt  in  1  enter HALT state.
REQ-008 resume  in  1  leave HALT state.
REQ-009 br_taken  in  1  conditional branch taken.
REQ-010 br_off  in  8  signed two's-complement word offset.
REQ-011 jmp  in  1  absolute jump.
REQ-012 jmp_addr  in  16  jump / call target.
REQ-013 call  in  1  jump to jmp_addr, push return address.
REQ-014 ret  in  1  pop return address, jump to it.
REQ-015 next_pc  out  16  value to load into the PC register.
REQ-016 pc_we  out  1  PC register write enable.
REQ-017 halted  out  1  high while in HALT.
REQ-018 ras_ovf  out  1  sticky: push attempted when stack full.
REQ-019 ras_unf  out  1  sticky: pop attempted when stack empty.

Function
REQ-020 FSM states BOOT, RUN, HALT; BOOT->RUN unconditionally after one clock; RUN->HALT when halt=1 and stall=0; HALT->RUN when resume=1.
REQ-021 next_pc and pc_we are combinational from state, inputs and stack top; zero added latency; PC register updates on the following edge.
REQ-022 BOOT: next_pc=RESET_VEC, pc_we=1, stack untouched.
REQ-023 RUN, stall=1: pc_we=0, next_pc=pc_cur, no stack change, no state change; stall overrides all other inputs.
REQ-024 RUN, stall=0, priority halt > ret > call > jmp > br_taken > sequential; only highest active request acts.
REQ-025 halt: pc_we=0, next_pc=pc_cur, go HALT.
REQ-026 ret: stack non-empty -> next_pc=top, pop; empty -> next_pc=pc_cur+1, set ras_unf, no pop.
REQ-027 call: next_pc=jmp_addr; not full -> push pc_cur+1; full -> no push, set ras_ovf, existing entries kept.
REQ-028 jmp: next_pc=jmp_addr; br_taken: next_pc=pc_cur+1+sign_ext(br_off); sequential: next_pc=pc_cur+1.
REQ-029 pc_we=1 for every RUN non-stall, non-halt cycle.
REQ-030 All address arithmetic 16-bit modulo 2^16; 16'hFFFF+1 wraps to 16'h0000; negative offsets wrap below 0.
REQ-031 HALT: pc_we=0, next_pc=pc_cur, halted=1; stall, branch, jump, call, ret ignored; resume cycle itself has pc_we=0.
REQ-032 ras_ovf, ras_unf remain set until rst.

Reset
REQ-033 rst=1 immediately: state=BOOT, stack empty, ras_ovf=0, ras_unf=0, halted=0, pc_we=0, next_pc=RESET_VEC.
REQ-034 rst asserted mid-operation (any state, stack in any fill level) discards all pending state; first cycle after release is BOOT.

Configuration
REQ-035 Macro PC_SEQ_RAS_EN defined: return-address stack, ret/call push/pop, ras_ovf/ras_unf present as specified.
REQ-036 PC_SEQ_RAS_EN undefined: no stack storage; call behaves as jmp; ret ignored (falls to next priority); ras_ovf=ras_unf=0 constant.

Verification
REQ-037 Release rst -> one cycle next_pc=RESET_VEC pc_we=1, then pc_cur=16'h0000 gives next_pc=16'h0001.
REQ-038 pc_cur=16'h0010, br_taken, br_off=8'hFC -> next_pc=16'h000D; pc_cur=16'hFFFF sequential -> 16'h0000.
REQ-039 RAS_EN: 4 calls at pc_cur 0x10,0x20,0x30,0x40, 5th call -> ras_ovf=1; 4 rets return 0x41,0x31,0x21,0x11; 5th ret -> next_pc=pc_cur+1, ras_unf=1.
REQ-040 stall=1 with call and jmp active -> pc_we=0, stack depth unchanged; call+ret same cycle -> ret taken.
REQ-041 halt -> halted=1, pc_we=0 for 10 cycles with jmp active; resume -> next cycle RUN, sequential resumes.
REQ-042 rst pulse while HALT with 2 stack entries and ras_ovf=1 -> flags 0, stack empty, BOOT sequence repeats.
